qick_cmd_arb: RTL and testbench

- Parametrised multi-source command arbiter; next generation of the single-slot processor/Python command register.
- Each of SRC_QTY sources pushes {op, data} commands into its own FIFO.
- A round-robin arbiter forwards one command at a time to the execution side over a level req/ack handshake, tagged with the source index.
- Sits between command producers (tProcessor, PS-side synchronised port, peer cores) and the command executor, in the core clock domain.

---
 rtl/qick_cmd_arb_pkg.sv | 38 +++
 rtl/qick_cmd_fifo.sv | 47 ++++
 rtl/qick_cmd_arb.sv | 153 +++++++++++++++
 tb/tb_qick_cmd_arb.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/qick_cmd_arb_pkg.sv
// Shared types and the source-selection helper for the qick_cmd_arb command arbiter.
package qick_cmd_arb_pkg;

    localparam int unsigned SRC_IW     = 3;
    localparam int unsigned CNT_W      = 8;
    localparam int unsigned CMD_OP_DW  = 5;
    localparam int unsigned CMD_DT_QTY = 4;

    typedef enum logic {
        IDLE,
        REQ
    } state_t;

    typedef struct packed {
        logic [CMD_OP_DW-1:0]        op;
        logic [CMD_DT_QTY-1:0][31:0] dt;
    } cmd_t;

    // Returns {found, index}: first set bit of req at or after base, wrapping at qty.
    function automatic logic [SRC_IW:0] rr_pick(
        input logic [7:0]        req,
        input logic [SRC_IW-1:0] base,
        input int unsigned       qty
    );
        logic [SRC_IW:0] res;
        int unsigned     idx;
        res = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (i < qty) begin
                idx = 32'(base) + i;
                if (idx >= qty) idx = idx - qty;
                if (req[idx[2:0]] && !res[SRC_IW]) res = {1'b1, idx[2:0]};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/qick_cmd_fifo.sv
// Single-clock first-word-fall-through FIFO holding one packed {op, data} command per entry.
module qick_cmd_fifo
    import qick_cmd_arb_pkg::*;
#(
    parameter int unsigned W  = 133,
    parameter int unsigned AW = 3
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] data_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int unsigned DEPTH = 2**AW;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   cnt_q;
    logic          do_push, do_pop;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign data_o  = mem[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr_q] <= data_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/qick_cmd_arb.sv
// Multi-source command arbiter: per-source FIFOs feeding a req/ack executor port.
// Define QICK_CMD_ARB_PRIO_EN for fixed lowest-index priority instead of round-robin.
module qick_cmd_arb
    import qick_cmd_arb_pkg::*;
#(
    parameter int unsigned SRC_QTY = 2,
    parameter int unsigned OP_DW   = 5,
    parameter int unsigned DT_QTY  = 4,
    parameter int unsigned FIFO_AW = 3
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [SRC_QTY-1:0]          src_en_i,
    input  logic [SRC_QTY*OP_DW-1:0]    src_op_i,
    input  logic [SRC_QTY*DT_QTY*32-1:0] src_dt_i,
    output logic [SRC_QTY-1:0]          src_full_o,
    output logic                        cmd_req_o,
    input  logic                        cmd_ack_i,
    output logic [OP_DW-1:0]            cmd_op_o,
    output logic [DT_QTY*32-1:0]        cmd_dt_o,
    output logic [SRC_IW-1:0]           cmd_src_o,
    output logic [SRC_QTY-1:0]          cmd_ovf_o,
    input  logic                        ovf_clr_i,
    output logic [SRC_QTY*CNT_W-1:0]    cmd_cnt_do
);

    localparam int unsigned CW = OP_DW + DT_QTY*32;

    logic [CW-1:0]        fifo_dout [SRC_QTY];
    logic [SRC_QTY-1:0]   fifo_full, fifo_empty, fifo_pop;
    logic [CW-1:0]        sel_cmd;
    logic [SRC_IW:0]      pick;
    logic [SRC_IW-1:0]    grant_idx, rr_base;
    logic                 grant_any, load, done;
    state_t               state_q, state_d;
    logic [OP_DW-1:0]     op_q;
    logic [DT_QTY*32-1:0] dt_q;
    logic [SRC_IW-1:0]    src_q;
    logic [SRC_QTY-1:0]   ovf_q;
    logic [CNT_W-1:0]     cnt_q [SRC_QTY];

    for (genvar s = 0; s < SRC_QTY; s++) begin : g_src
        qick_cmd_fifo #(
            .W  (CW),
            .AW (FIFO_AW)
        ) u_fifo (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .push_i  (src_en_i[s]),
            .data_i  ({src_op_i[s*OP_DW +: OP_DW], src_dt_i[s*DT_QTY*32 +: DT_QTY*32]}),
            .pop_i   (fifo_pop[s]),
            .data_o  (fifo_dout[s]),
            .full_o  (fifo_full[s]),
            .empty_o (fifo_empty[s])
        );
        assign cmd_cnt_do[s*CNT_W +: CNT_W] = cnt_q[s];
    end

    assign src_full_o = fifo_full;
    assign pick       = rr_pick(8'(~fifo_empty), rr_base, SRC_QTY);
    assign grant_any  = pick[SRC_IW];
    assign grant_idx  = pick[SRC_IW-1:0];

`ifdef QICK_CMD_ARB_PRIO_EN
    assign rr_base = '0;
`else
    logic [SRC_IW-1:0] rr_ptr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q <= '0;
        end else if (load) begin
            rr_ptr_q <= (grant_idx == SRC_IW'(SRC_QTY-1)) ? '0 : grant_idx + 1'b1;
        end
    end

    assign rr_base = rr_ptr_q;
`endif

    always_comb begin
        sel_cmd = '0;
        for (int unsigned s = 0; s < SRC_QTY; s++) begin
            if (grant_idx == SRC_IW'(s)) sel_cmd = fifo_dout[s];
        end
    end

    always_comb begin
        state_d  = state_q;
        fifo_pop = '0;
        load     = 1'b0;
        done     = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_any) begin
                    load    = 1'b1;
                    state_d = REQ;
                    for (int unsigned s = 0; s < SRC_QTY; s++) begin
                        fifo_pop[s] = (grant_idx == SRC_IW'(s));
                    end
                end
            end
            REQ: begin
                if (cmd_ack_i) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            op_q    <= '0;
            dt_q    <= '0;
            src_q   <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                op_q  <= sel_cmd[CW-1 -: OP_DW];
                dt_q  <= sel_cmd[DT_QTY*32-1:0];
                src_q <= grant_idx;
            end
        end
    end

    // A same-cycle overflow wins over the clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ovf_q <= '0;
        end else begin
            ovf_q <= (ovf_clr_i ? '0 : ovf_q) | (src_en_i & fifo_full);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned s = 0; s < SRC_QTY; s++) cnt_q[s] <= '0;
        end else if (done) begin
            for (int unsigned s = 0; s < SRC_QTY; s++) begin
                if (src_q == SRC_IW'(s)) cnt_q[s] <= cnt_q[s] + 1'b1;
            end
        end
    end

    assign cmd_req_o = (state_q == REQ);
    assign cmd_op_o  = op_q;
    assign cmd_dt_o  = dt_q;
    assign cmd_src_o = src_q;
    assign cmd_ovf_o = ovf_q;

endmodule

// File: tb/tb_qick_cmd_arb.sv
// Scoreboard bench for qick_cmd_arb (SRC_QTY=2); expectations follow QICK_CMD_ARB_PRIO_EN.
module tb_qick_cmd_arb;

    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b0;
    logic [1:0]   src_en_i = '0;
    logic [9:0]   src_op_i = '0;
    logic [255:0] src_dt_i = '0;
    logic [1:0]   src_full_o;
    logic         cmd_req_o;
    logic         cmd_ack_i = 1'b0;
    logic [4:0]   cmd_op_o;
    logic [127:0] cmd_dt_o;
    logic [2:0]   cmd_src_o;
    logic [1:0]   cmd_ovf_o;
    logic         ovf_clr_i = 1'b0;
    logic [15:0]  cmd_cnt_do;

    typedef struct {
        logic [2:0]   src;
        logic [4:0]   op;
        logic [127:0] dt;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    logic req_prev = 1'b0;

    qick_cmd_arb #(
        .SRC_QTY (2),
        .OP_DW   (5),
        .DT_QTY  (4),
        .FIFO_AW (3)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .src_en_i   (src_en_i),
        .src_op_i   (src_op_i),
        .src_dt_i   (src_dt_i),
        .src_full_o (src_full_o),
        .cmd_req_o  (cmd_req_o),
        .cmd_ack_i  (cmd_ack_i),
        .cmd_op_o   (cmd_op_o),
        .cmd_dt_o   (cmd_dt_o),
        .cmd_src_o  (cmd_src_o),
        .cmd_ovf_o  (cmd_ovf_o),
        .ovf_clr_i  (ovf_clr_i),
        .cmd_cnt_do (cmd_cnt_do)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: every new request is matched against the head of the scoreboard.
    always @(negedge clk_i) begin : monitor
        exp_t e;
        if (rst_ni && cmd_req_o && !req_prev) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_req: got src %0d op %0h expected no request", cmd_src_o, cmd_op_o);
            end else begin
                e = exp_q.pop_front();
                check("grant_src", 128'(cmd_src_o), 128'(e.src));
                check("grant_op", 128'(cmd_op_o), 128'(e.op));
                check("grant_dt", cmd_dt_o, e.dt);
            end
        end
        req_prev = cmd_req_o;
    end

    function automatic logic [127:0] mk_dt(input logic [31:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    task automatic set_src(input int s, input logic [4:0] op, input logic [127:0] dt);
        src_en_i[s]           = 1'b1;
        src_op_i[s*5 +: 5]    = op;
        src_dt_i[s*128 +: 128] = dt;
    endtask

    task automatic exp_push(input int s, input logic [4:0] op, input logic [127:0] dt);
        exp_t e;
        e.src = 3'(s);
        e.op  = op;
        e.dt  = dt;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
        src_en_i  = '0;
        ovf_clr_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_ni    = 1'b0;
        src_en_i  = '0;
        cmd_ack_i = 1'b0;
        ovf_clr_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        tick();
    endtask

    task automatic wait_drain(input int budget, input string name);
        bit ok = 0;
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0 && !cmd_req_o) begin
                ok = 1;
                break;
            end
            tick();
        end
        if (!ok) begin
            n_chk++;
            $display("FAIL %s: got %0d pending commands expected 0 within %0d cycles", name, exp_q.size(), budget);
            exp_q.delete();
        end
    endtask

    task automatic wait_req(input int budget, input string name);
        bit ok = 0;
        for (int i = 0; i < budget; i++) begin
            if (cmd_req_o) begin
                ok = 1;
                break;
            end
            tick();
        end
        if (!ok) begin
            n_chk++;
            $display("FAIL %s: got req 0 expected 1 within %0d cycles", name, budget);
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ctl"}, 128'({cmd_req_o, cmd_op_o, cmd_src_o, cmd_ovf_o, src_full_o}), '0);
        check({name, "_dt"}, cmd_dt_o, '0);
        check({name, "_cnt"}, 128'(cmd_cnt_do), '0);
    endtask

    initial begin
        logic [127:0] d;
        #2;
        check_all_zero("rst_async");
        do_reset();
        check_all_zero("rst_state");

        // Single command, latency and held ack
        d = mk_dt(32'd1, 32'd2, 32'd3, 32'd4);
        exp_push(0, 5'h03, d);
        set_src(0, 5'h03, d);
        tick();
        check("lat_cycle1_req", 128'(cmd_req_o), 128'(0));
        tick();
        check("lat_cycle2_req", 128'(cmd_req_o), 128'(1));
        cmd_ack_i = 1'b1;
        tick();
        check("ack_req_low", 128'(cmd_req_o), 128'(0));
        check("ack_cnt0", 128'(cmd_cnt_do[7:0]), 128'(1));
        tick();
        tick();
        cmd_ack_i = 1'b0;
        check("ack_hold_req", 128'(cmd_req_o), 128'(0));
        check("ack_hold_cnt0", 128'(cmd_cnt_do), 128'(16'h0001));
        check("op_retained", 128'(cmd_op_o), 128'(5'h03));

        // Two sources pushing together, always acked
        do_reset();
        cmd_ack_i = 1'b1;
`ifdef QICK_CMD_ARB_PRIO_EN
        exp_push(0, 5'h0A, mk_dt(32'hA0, 32'hA1, 32'hA2, 32'hA3));
        exp_push(0, 5'h0B, mk_dt(32'hB0, 32'hB1, 32'hB2, 32'hB3));
        exp_push(1, 5'h1A, mk_dt(32'hC0, 32'hC1, 32'hC2, 32'hC3));
        exp_push(1, 5'h1B, mk_dt(32'hD0, 32'hD1, 32'hD2, 32'hD3));
`else
        exp_push(0, 5'h0A, mk_dt(32'hA0, 32'hA1, 32'hA2, 32'hA3));
        exp_push(1, 5'h1A, mk_dt(32'hC0, 32'hC1, 32'hC2, 32'hC3));
        exp_push(0, 5'h0B, mk_dt(32'hB0, 32'hB1, 32'hB2, 32'hB3));
        exp_push(1, 5'h1B, mk_dt(32'hD0, 32'hD1, 32'hD2, 32'hD3));
`endif
        set_src(0, 5'h0A, mk_dt(32'hA0, 32'hA1, 32'hA2, 32'hA3));
        set_src(1, 5'h1A, mk_dt(32'hC0, 32'hC1, 32'hC2, 32'hC3));
        tick();
        set_src(0, 5'h0B, mk_dt(32'hB0, 32'hB1, 32'hB2, 32'hB3));
        set_src(1, 5'h1B, mk_dt(32'hD0, 32'hD1, 32'hD2, 32'hD3));
        tick();
        wait_drain(40, "arb_drain");
        check("arb_cnt", 128'(cmd_cnt_do), 128'(16'h0202));

        // Fill src1 with ack low, overflow, clear
        do_reset();
        for (int k = 0; k < 9; k++) begin
            d = mk_dt(32'h100 + 32'(k), 32'h200 + 32'(k), 32'h300 + 32'(k), 32'h400 + 32'(k));
            exp_push(1, 5'h10 + 5'(k), d);
            set_src(1, 5'h10 + 5'(k), d);
            tick();
            if (k == 7) check("full_after8", 128'(src_full_o), 128'(2'b00));
        end
        check("full_after9", 128'(src_full_o), 128'(2'b10));
        check("ovf_before", 128'(cmd_ovf_o), 128'(2'b00));
        set_src(1, 5'h1F, '1);
        tick();
        check("ovf_set", 128'(cmd_ovf_o), 128'(2'b10));
        set_src(1, 5'h1E, '1);
        ovf_clr_i = 1'b1;
        tick();
        check("ovf_set_wins", 128'(cmd_ovf_o), 128'(2'b10));
        ovf_clr_i = 1'b1;
        tick();
        check("ovf_clear", 128'(cmd_ovf_o), 128'(2'b00));
        cmd_ack_i = 1'b1;
        wait_drain(60, "fill_drain");
        check("fill_cnt", 128'(cmd_cnt_do), 128'(16'h0900));
        check("fill_not_full", 128'(src_full_o), 128'(2'b00));

        // Ack while idle and empty
        for (int k = 0; k < 4; k++) begin
            tick();
            check("idle_ack_req", 128'(cmd_req_o), 128'(0));
        end
        check("idle_ack_cnt", 128'(cmd_cnt_do), 128'(16'h0900));
        cmd_ack_i = 1'b0;

        // Reset during REQ with three commands queued
        do_reset();
        for (int k = 0; k < 4; k++) begin
            d = mk_dt(32'hE0 + 32'(k), 32'hE1, 32'hE2, 32'hE3);
            if (k == 0) exp_push(0, 5'h05, d);
            set_src(0, 5'h05 + 5'(k), d);
            tick();
        end
        wait_req(10, "pre_rst_req");
        @(posedge clk_i);
        #3 rst_ni = 1'b0;
        #1;
        check_all_zero("rst_in_req");
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("post_rst_req", 128'(cmd_req_o), 128'(0));
        end
        check("post_rst_full", 128'(src_full_o), 128'(2'b00));

        // Counter wrap on src0
        do_reset();
        cmd_ack_i = 1'b1;
        for (int i = 0; i < 255; i++) begin
            d = mk_dt(32'(i), ~32'(i), 32'(i) * 3, 32'hA5A50000 | 32'(i));
            exp_push(0, 5'(i), d);
            set_src(0, 5'(i), d);
            tick();
            tick();
        end
        wait_drain(40, "wrap_drain255");
        check("cnt_255", 128'(cmd_cnt_do[7:0]), 128'(8'd255));
        d = mk_dt(32'hFFFF, 32'h0, 32'h1, 32'h2);
        exp_push(0, 5'h1C, d);
        set_src(0, 5'h1C, d);
        tick();
        wait_drain(40, "wrap_drain256");
        check("cnt_wrap", 128'(cmd_cnt_do), 128'(16'h0000));
        cmd_ack_i = 1'b0;

        tick();
        check("sb_empty", 128'(exp_q.size()), 128'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
